// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared FSM states, mode codes and LED constants for the LED scan sequencer.
package led_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  localparam logic [1:0] MODE_UP = 2'b00;
  localparam logic [1:0] MODE_DN = 2'b01;
  localparam logic [1:0] MODE_BNC = 2'b10;
  localparam logic [1:0] MODE_MAN = 2'b11;
  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  function automatic logic [7:0] led_decode(input logic [2:0] s);
    return LED_ALL_OFF ^ (8'h80 >> s);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability filter and one-cycle press pulse for a raw button.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level, flip;
  // flip fires on the last of DEB_CYCLES consecutive cycles that disagree with the accepted level
  assign flip = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync[1] : level;
      pulse <= flip & sync[1];
    end
  end
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: steps a 3-bit LED position (up/down/bounce/manual) and drives a one-cold LED bank.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  input  logic [2:0] man_sel,
  output logic [2:0] sel,
  output logic [7:0] led,
  output logic       running
);
  localparam int TW = $clog2(TICK_DIV);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n, lim;
  logic [2:0] sel_n, nxt;
  logic dir_dn, dir_dn_n, nxt_dn;
  logic run_p, step_p, term, adv, man;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk(clk), .rst_n(rst_n), .btn(btn_run), .pulse(run_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(clk), .rst_n(rst_n), .btn(btn_step), .pulse(step_p)
  );

  assign man = mode == MODE_MAN;
  assign lim = TW'((TICK_DIV >> speed) - 1);
  // >= rather than == so a faster speed chosen mid-count fires at once
  assign term = cnt >= lim;
  assign adv = (state == RUN) ? term : (step_p && !run_p);
  assign led = led_decode(sel);
  assign running = state == RUN;

  always_comb begin
    state_n = state;
    if (run_p) state_n = (state == RUN) ? PAUSE : RUN;
  end

  always_comb begin
    nxt_dn = (mode == MODE_DN) ? 1'b1
           : (mode == MODE_BNC) ? (dir_dn ? (sel != 3'd0) : (sel == 3'd7))
           : 1'b0;
    nxt = nxt_dn ? sel - 3'd1 : sel + 3'd1;
    sel_n = man ? man_sel : (adv ? nxt : sel);
    dir_dn_n = (!man && adv) ? nxt_dn : dir_dn;
    cnt_n = (state != RUN || man || term) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= 3'd0;
      dir_dn <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      dir_dn <= dir_dn_n;
      cnt <= cnt_n;
    end
  end
endmodule
